uart_msg_decoder: RTL and testbench

- Parametrised successor to the HC-05 receive path: a UART byte receiver plus a framed command decoder for laptop-to-bot traversal messages.
- Commands are matched by character position, not by character-set membership:
  - "IFM-xU-#" selects a traversal unit.
  - "PBM-SU-Bn-#" selects a supply unit.
- Adds input synchronisation, start-bit glitch rejection, framing and message error reporting, and a configurable unit count and pulse length.
- Sits between the HC-05 RX pin and the bot path-planning FSM.

---
 rtl/uart_msg_pkg.sv | 38 +++
 rtl/uart_rx_core.sv | 122 ++++++++++++
 rtl/uart_msg_decoder.sv | 190 +++++++++++++++++++
 tb/tb_uart_msg_decoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_pkg.sv
// Shared constants and state encodings for the
// HC-05 UART receive path and command decoder.
package uart_msg_pkg;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  localparam logic [1:0] UNIT_EU   = 2'd0;
  localparam logic [1:0] UNIT_CU   = 2'd1;
  localparam logic [1:0] UNIT_RU   = 2'd2;
  localparam logic [1:0] UNIT_NONE = 2'd3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    M_IDLE,
    M_COLLECT
  } msg_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 2-FF input synchroniser,
// start-bit glitch rejection and framing error strobe.
module uart_rx_core
  import uart_msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          hold_q, hold_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, rxs_q;
  logic          tick_half, tick_full;

  assign tick_half = (cnt_q == HALF_M1);
  assign tick_full = (cnt_q == FULL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (!rxs_q) state_d = RX_START;
      RX_START: if (tick_half) state_d = rxs_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP: begin
        if (hold_q) begin
          if (rxs_q) state_d = RX_IDLE;
        end else if (tick_full && rxs_q) begin
          state_d = RX_IDLE;
        end
      end
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    hold_d  = hold_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      RX_START: if (tick_half) cnt_d = '0;
      RX_DATA: begin
        if (tick_full) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        // after a bad stop bit, idle until the line recovers
        if (hold_q) begin
          cnt_d = '0;
          if (rxs_q) hold_d = 1'b0;
        end else if (tick_full) begin
          cnt_d = '0;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            hold_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_msg_decoder.sv
// HC-05 receive path: UART receiver, framed message
// assembler and positional IFM/PBM command matcher.
module uart_msg_decoder
  import uart_msg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_MSG_LEN  = 12,
  parameter int NUM_SU       = 4,
  parameter int PULSE_CYCLES = 16,
  parameter int SU_W         = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  output logic [7:0]      byte_data,
  output logic            byte_valid,
  output logic            frame_err,
  output logic            msg_err,
  output logic            unit_msg,
  output logic [1:0]      unit_pulse,
  output logic [SU_W-1:0] su,
  output logic            pbm_complete,
  output logic [2:0]      msg_count
);

  localparam int LW = $clog2(MAX_MSG_LEN + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  msg_state_e      mst_q, mst_d;
  logic [7:0]      mbuf_q [MAX_MSG_LEN];
  logic [7:0]      mbuf_d [MAX_MSG_LEN];
  logic [LW-1:0]   len_q, len_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            err_q, err_d;
  logic            umsg_q, umsg_d;
  logic [1:0]      unit_q, unit_d;
  logic [SU_W-1:0] su_q, su_d;
  logic            pbm_q, pbm_d;
  logic [2:0]      cnt_q, cnt_d;

  logic            is_start, is_hash, full;
  logic            ifm_hit, pbm_hit, dig_ok;
  logic [1:0]      code;
  logic [7:0]      dig;
  logic [SU_W-1:0] idx;

  assign is_start = (rx_byte == CH_I) || (rx_byte == CH_P);
  assign is_hash  = (rx_byte == CH_HASH);
  assign full     = (len_q == LW'(MAX_MSG_LEN));

  always_comb begin
    unique case (1'b1)
      (mbuf_q[4] == CH_E): code = UNIT_EU;
      (mbuf_q[4] == CH_C): code = UNIT_CU;
      (mbuf_q[4] == CH_R): code = UNIT_RU;
      default:             code = UNIT_NONE;
    endcase
  end

  // buffer excludes the terminating '#', which is the byte in flight
  assign ifm_hit = (len_q == LW'(7)) && (code != UNIT_NONE)
                && (mbuf_q[0] == CH_I) && (mbuf_q[1] == CH_F)
                && (mbuf_q[2] == CH_M) && (mbuf_q[3] == CH_DASH)
                && (mbuf_q[5] == CH_U) && (mbuf_q[6] == CH_DASH);

  assign dig    = mbuf_q[8];
  assign dig_ok = (dig >= CH_1) && (dig < CH_1 + 8'(NUM_SU));
  assign idx    = SU_W'(dig - CH_1);

  assign pbm_hit = (len_q == LW'(10)) && dig_ok
                && (mbuf_q[0] == CH_P) && (mbuf_q[1] == CH_B)
                && (mbuf_q[2] == CH_M) && (mbuf_q[3] == CH_DASH)
                && (mbuf_q[4] == CH_S) && (mbuf_q[5] == CH_U)
                && (mbuf_q[6] == CH_DASH) && (mbuf_q[7] == CH_B)
                && (mbuf_q[9] == CH_DASH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_q  <= M_IDLE;
      for (int i = 0; i < MAX_MSG_LEN; i++) mbuf_q[i] <= '0;
      len_q  <= '0;
      pcnt_q <= '0;
      err_q  <= 1'b0;
      umsg_q <= 1'b0;
      unit_q <= UNIT_NONE;
      su_q   <= SU_W'(NUM_SU);
      pbm_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mst_q  <= mst_d;
      mbuf_q <= mbuf_d;
      len_q  <= len_d;
      pcnt_q <= pcnt_d;
      err_q  <= err_d;
      umsg_q <= umsg_d;
      unit_q <= unit_d;
      su_q   <= su_d;
      pbm_q  <= pbm_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    mst_d = mst_q;
    unique case (mst_q)
      M_IDLE:    if (rx_valid && is_start) mst_d = M_COLLECT;
      M_COLLECT: if (rx_ferr || (rx_valid && (is_hash || full))) mst_d = M_IDLE;
      default:   mst_d = M_IDLE;
    endcase
  end

  always_comb begin
    mbuf_d = mbuf_q;
    len_d  = len_q;
    pcnt_d = pcnt_q;
    err_d  = 1'b0;
    umsg_d = umsg_q;
    unit_d = unit_q;
    su_d   = su_q;
    pbm_d  = pbm_q;
    cnt_d  = cnt_q;
    if (umsg_q) begin
      if (pcnt_q == '0) umsg_d = 1'b0;
      else pcnt_d = pcnt_q - 1'b1;
    end
    unique case (mst_q)
      M_IDLE: begin
        if (rx_valid && is_start) begin
          mbuf_d[0] = rx_byte;
          len_d     = LW'(1);
        end
      end
      M_COLLECT: begin
        if (rx_ferr) begin
          err_d = 1'b1;
          len_d = '0;
        end else if (rx_valid) begin
          if (is_hash) begin
            len_d = '0;
            if (ifm_hit) begin
              unit_d = code;
              pbm_d  = 1'b0;
              cnt_d  = cnt_q + 3'd1;
              umsg_d = 1'b1;
              pcnt_d = PW'(PULSE_CYCLES - 1);
            end else if (pbm_hit) begin
              su_d   = idx;
              pbm_d  = 1'b1;
              umsg_d = 1'b0;
              pcnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end else if (full) begin
            err_d = 1'b1;
            len_d = '0;
          end else begin
            for (int i = 0; i < MAX_MSG_LEN; i++)
              if (len_q == LW'(i)) mbuf_d[i] = rx_byte;
            len_d = len_q + 1'b1;
          end
        end
      end
      default: len_d = '0;
    endcase
  end

  assign byte_data    = rx_byte;
  assign byte_valid   = rx_valid;
  assign frame_err    = rx_ferr;
  assign msg_err      = err_q;
  assign unit_msg     = umsg_q;
  assign unit_pulse   = unit_q;
  assign su           = su_q;
  assign pbm_complete = pbm_q;
  assign msg_count    = cnt_q;

endmodule

// File: tb/tb_uart_msg_decoder.sv
// Self-checking bench for uart_msg_decoder: table of messages
// with expected outputs, scoreboard popped on decode events.
module tb_uart_msg_decoder;

  localparam int CPB   = 32;
  localparam int NSU   = 4;
  localparam int PULSE = 16;
  localparam int SUW   = 3;
  localparam int NVEC  = 11;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx = 1'b1;
  logic [7:0]     byte_data;
  logic           byte_valid, frame_err, msg_err, unit_msg;
  logic [1:0]     unit_pulse;
  logic [SUW-1:0] su;
  logic           pbm_complete;
  logic [2:0]     msg_count;

  uart_msg_decoder #(
    .CLKS_PER_BIT(CPB),
    .MAX_MSG_LEN (12),
    .NUM_SU      (NSU),
    .PULSE_CYCLES(PULSE),
    .SU_W        (SUW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .frame_err   (frame_err),
    .msg_err     (msg_err),
    .unit_msg    (unit_msg),
    .unit_pulse  (unit_pulse),
    .su          (su),
    .pbm_complete(pbm_complete),
    .msg_count   (msg_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       err;
    logic [1:0] unit;
    logic [2:0] cnt;
    logic [2:0] su;
    bit       pbm;
    bit       umsg;
  } exp_t;

  typedef struct {
    logic [127:0] txt;
    int           len;
    exp_t         exp;
  } vec_t;

  exp_t sb[$];
  vec_t tv[NVEC];

  int checks = 0;
  int failures = 0;
  int nbytes = 0;
  int nferr = 0;
  int run_len = 0;
  int last_run = 0;
  int run_id = 0;
  bit prev_hash = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mke(input bit err, input logic [1:0] u,
                               input logic [2:0] c, input logic [2:0] s,
                               input bit p, input bit m);
    exp_t e;
    e.err = err; e.unit = u; e.cnt = c;
    e.su = s; e.pbm = p; e.umsg = m;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [127:0] t, input int n,
                               input exp_t e);
    vec_t v;
    v.txt = t; v.len = n; v.exp = e;
    return v;
  endfunction

  // decode events: cycle after a '#' strobe, or any other msg_err
  always @(negedge clk) begin
    exp_t e;
    if (byte_valid) nbytes++;
    if (frame_err) nferr++;
    if (unit_msg) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_id++;
      run_len = 0;
    end
    if (prev_hash || msg_err) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_event", 1, 0);
      end else begin
        e = sb.pop_front();
        check("msg_err", msg_err, e.err);
        check("unit_pulse", unit_pulse, e.unit);
        check("msg_count", msg_count, e.cnt);
        check("su", su, e.su);
        check("pbm_complete", pbm_complete, e.pbm);
        check("unit_msg", unit_msg, e.umsg);
      end
    end
    prev_hash = byte_valid && (byte_data == 8'h23);
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_msg(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      if (i == v.len - 1) sb.push_back(v.exp);
      send_byte(v.txt[8*(v.len-1-i) +: 8], 1'b1);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_byte_data"}, byte_data, 0);
    check({tag, "_byte_valid"}, byte_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_msg_err"}, msg_err, 0);
    check({tag, "_unit_msg"}, unit_msg, 0);
    check({tag, "_unit_pulse"}, unit_pulse, 3);
    check({tag, "_su"}, su, NSU);
    check({tag, "_pbm"}, pbm_complete, 0);
    check({tag, "_count"}, msg_count, 0);
  endtask

  initial begin
    int b0, f0, r0;
    vec_t v;

    tv[0]  = mkv("IFM-CU-#", 8, mke(0, 1, 1, 4, 0, 1));
    tv[1]  = mkv("PBM-SU-B3-#", 11, mke(0, 1, 1, 2, 1, 0));
    tv[2]  = mkv("IFM-XU-#", 8, mke(1, 1, 1, 2, 1, 0));
    tv[3]  = mkv("PBM-SU-B5-#", 11, mke(1, 1, 1, 2, 1, 0));
    tv[4]  = mkv("IFM-EU-------", 13, mke(1, 1, 1, 2, 1, 0));
    tv[5]  = mkv("IFM-RU-#", 8, mke(0, 2, 2, 2, 0, 1));
    tv[6]  = mkv({8'h0D, 8'h0A, "PBM-SU-B1-#"}, 13,
                 mke(0, 2, 2, 0, 1, 0));
    tv[7]  = mkv("PBM-SU-B0-#", 11, mke(1, 2, 2, 0, 1, 0));
    tv[8]  = mkv("IFM-EU-#", 8, mke(0, 0, 3, 0, 0, 1));
    tv[9]  = mkv("PBM-SU-B4-#", 11, mke(0, 0, 3, 3, 1, 0));
    tv[10] = mkv("IFM-RU-#", 8, mke(0, 2, 4, 3, 0, 1));

    rx = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset("rst0");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      b0 = nbytes;
      r0 = run_id;
      send_msg(tv[i]);
      repeat (2 * PULSE + 8) @(negedge clk);
      check($sformatf("v%0d_bytes", i), nbytes - b0, tv[i].len);
      if (tv[i].exp.umsg) begin
        check($sformatf("v%0d_pulse_runs", i), run_id - r0, 1);
        check($sformatf("v%0d_pulse_len", i), last_run, PULSE);
      end
    end

    // msg_count wrap 4 -> 5,6,7,0
    for (int k = 0; k < 4; k++) begin
      v = mkv("IFM-CU-#", 8, mke(0, 1, 3'((5 + k) % 8), 3, 0, 1));
      send_msg(v);
      repeat (2 * PULSE + 8) @(negedge clk);
    end
    check("wrap_count", msg_count, 0);

    // short start glitch, then 'I' and a byte with bad stop bit
    b0 = nbytes;
    f0 = nferr;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 5) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_bytes", nbytes - b0, 0);
    check("glitch_ferr", nferr - f0, 0);
    send_byte(8'h49, 1'b1);
    sb.push_back(mke(1, 1, 0, 3, 0, 0));
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("bad_stop_ferr", nferr - f0, 1);
    check("bad_stop_bytes", nbytes - b0, 1);

    // reset in the middle of byte 4 of "IFM-EU-#"
    send_byte(8'h49, 1'b1);
    send_byte(8'h46, 1'b1);
    send_byte(8'h4D, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst_mid");
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_reset("rst_after");
    b0 = nbytes;
    send_msg(mkv("IFM-EU-#", 8, mke(0, 0, 1, 4, 0, 1)));
    repeat (2 * PULSE + 8) @(negedge clk);
    check("post_rst_bytes", nbytes - b0, 8);

    repeat (50) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
